// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: replays a byte/end-flag command table into a bytewise I2C transmitter.
module i2c_cmd_seq #(
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int GAP_EDGES = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [8:0]    cfg_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          clk_i2c,
    output logic          tx_rd_en,
    output logic [7:0]    tx_data,
    input  logic          tx_sent,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_EDGES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, GAP, DONE} state_t;

    state_t        state, state_nxt;
    logic [8:0]    mem [DEPTH];
    logic [8:0]    entry;
    logic [AW-1:0] ptr;
    logic [AW:0]   len_q;
    logic [TW-1:0] tmo;
    logic [GW-1:0] gcnt;
    logic          i2c_q, zero_done, error_q;
    logic          fall, is_last, expire, gap_end, accept;

    assign fall    = i2c_q & ~clk_i2c;
    assign is_last = {1'b0, ptr} == len_q - 1'b1;
    assign expire  = tmo <= TW'(1);
    assign gap_end = fall && gcnt == GW'(GAP_EDGES - 1);
    assign accept  = state == IDLE && start && len != '0;

    // Table is only writable between sequences so a running script never changes underneath.
    always_ff @(posedge clk)
        if (cfg_we && !busy && {1'b0, cfg_addr} < (AW + 1)'(DEPTH))
            mem[cfg_addr] <= cfg_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? FETCH : IDLE;
            FETCH:   state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = tx_sent ? ((entry[8] || is_last) ? GAP : FETCH) : (expire ? GAP : WAIT);
            GAP:     state_nxt = gap_end ? ((is_last || error_q) ? DONE : FETCH) : GAP;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_rd_en = state == ISSUE;
        tx_data  = entry[7:0];
        busy     = state != IDLE && state != DONE;
        done     = state == DONE || zero_done;
        error    = error_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            i2c_q     <= 1'b0;
            zero_done <= 1'b0;
            error_q   <= 1'b0;
            len_q     <= '0;
            ptr       <= '0;
            entry     <= '0;
            tmo       <= '0;
            gcnt      <= '0;
        end else begin
            i2c_q     <= clk_i2c;
            zero_done <= state == IDLE && start && len == '0;
            if (accept) begin
                len_q   <= len;
                ptr     <= '0;
                error_q <= 1'b0;
            end
            if (state == FETCH) entry <= mem[ptr];
            if (state == ISSUE) tmo <= TW'(TIMEOUT - 1);
            // sent has priority over expiry so a byte acknowledged on the last allowed cycle still counts
            if (state == WAIT) begin
                tmo  <= tmo - 1'b1;
                gcnt <= '0;
                if (tx_sent) begin
                    if (!(entry[8] || is_last)) ptr <= ptr + 1'b1;
                end else if (expire) begin
                    error_q <= 1'b1;
                end
            end
            if (state == GAP && fall) gcnt <= gcnt + 1'b1;
            if (state == GAP && gap_end && !(is_last || error_q)) ptr <= ptr + 1'b1;
        end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: directed-vector bench for i2c_cmd_seq with a hand-driven transmitter handshake.
module tb_i2c_cmd_seq;
    logic       clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, start = 1'b0, clk_i2c = 1'b0, tx_sent = 1'b0;
    logic [4:0] cfg_addr = '0;
    logic [8:0] cfg_data = '0;
    logic [5:0] len = '0;
    logic       tx_rd_en, busy, done, error;
    logic [7:0] tx_data;
    int         vectors = 0, miscompares = 0, rd_cnt = 0, falls = 0, n = 0;
    logic       pb;

    i2c_cmd_seq #(.DEPTH(32), .AW(5), .GAP_EDGES(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .len(len), .clk_i2c(clk_i2c), .tx_rd_en(tx_rd_en), .tx_data(tx_data),
        .tx_sent(tx_sent), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    initial begin
        #3;
        forever #40 clk_i2c = ~clk_i2c;
    end

    always @(negedge clk) if (tx_rd_en) rd_cnt++;
    always @(negedge clk_i2c) falls++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic write(input logic [4:0] a, input logic [8:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [5:0] l);
        start = 1'b1; len = l;
        tick;
        start = 1'b0;
    endtask

    task automatic send_sent;
        tx_sent = 1'b1;
        tick;
        tx_sent = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        n = 0;
        do begin tick; n++; end while (!tx_rd_en && n < 500);
        check(tag, tx_rd_en, 1);
    endtask

    task automatic wait_done(input string tag);
        n = 0;
        do begin pb = busy; tick; n++; end while (!done && n < 500);
        check(tag, done, 1);
    endtask

    initial begin
        tick; tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rd_en", tx_rd_en, 0);
        check("rst_data", tx_data, 0);
        rst_n = 1'b1;
        tick;
        write(5'd0, 9'h078);
        write(5'd1, 9'h100);
        write(5'd2, 9'h1AF);

        // three bytes: 0x78/0x00 chained, then 0xAF after a STOP gap
        rd_cnt = 0;
        do_start(3);
        check("t1_busy", busy, 1);
        wait_issue("t1_issue0");
        check("t1_data0", tx_data, 16'h78);
        tick;
        check("t1_pulse_width", tx_rd_en, 0);
        send_sent;
        check("t1_chain_early", tx_rd_en, 0);
        tick;
        check("t1_chain_rd", tx_rd_en, 1);
        check("t1_data1", tx_data, 16'h00);
        tick;
        falls = 0;
        send_sent;
        wait_issue("t1_issue2");
        check("t1_gap_falls", falls >= 2, 1);
        check("t1_data2", tx_data, 16'hAF);
        tick;
        send_sent;
        wait_done("t1_done");
        check("t1_busy_before", pb, 1);
        check("t1_busy_at_done", busy, 0);
        check("t1_error", error, 0);
        tick;
        check("t1_done_width", done, 0);
        check("t1_rd_count", rd_cnt, 3);

        // len = 0 completes immediately
        rd_cnt = 0;
        do_start(0);
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        tick;
        check("t2_done_width", done, 0);
        check("t2_busy_after", busy, 0);
        check("t2_rd_count", rd_cnt, 0);

        // no sent ever: error 16 cycles after the issue, rest skipped
        rd_cnt = 0;
        do_start(3);
        wait_issue("t3_issue0");
        repeat (15) tick;
        check("t3_error_early", error, 0);
        tick;
        check("t3_error_set", error, 1);
        wait_done("t3_done");
        check("t3_rd_count", rd_cnt, 1);
        check("t3_error_at_done", error, 1);
        tick;
        check("t3_error_sticky", error, 1);

        // start and table write while busy are ignored
        rd_cnt = 0;
        do_start(2);
        check("t4_error_cleared", error, 0);
        wait_issue("t4_issue0");
        check("t4_data0", tx_data, 16'h78);
        tick;
        start = 1'b1; len = 6'd3; cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 9'h155;
        tick;
        start = 1'b0; cfg_we = 1'b0;
        send_sent;
        tick;
        check("t4_chain_rd", tx_rd_en, 1);
        check("t4_data1", tx_data, 16'h00);
        tick;
        send_sent;
        wait_done("t4_done");
        check("t4_no_restart", rd_cnt, 2);
        tick;
        rd_cnt = 0;
        do_start(1);
        wait_issue("t4_readback");
        check("t4_tbl0_kept", tx_data, 16'h78);
        tick;
        send_sent;
        wait_done("t4_done2");
        tick;

        // reset while waiting on the second byte
        do_start(3);
        wait_issue("t5_issue0");
        tick;
        send_sent;
        tick;
        check("t5_issue1", tx_rd_en, 1);
        tick;
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_rd_en", tx_rd_en, 0);
        check("t5_done", done, 0);
        check("t5_data", tx_data, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // sent on the expiry cycle wins
        rd_cnt = 0;
        do_start(3);
        wait_issue("t6_issue0");
        check("t6_restart_e0", tx_data, 16'h78);
        repeat (15) tick;
        tx_sent = 1'b1;
        tick;
        tx_sent = 1'b0;
        check("t6_error", error, 0);
        check("t6_gap_cycle", tx_rd_en, 0);
        tick;
        check("t6_continue", tx_rd_en, 1);
        check("t6_data1", tx_data, 16'h00);
        tick;
        send_sent;
        wait_issue("t6_issue2");
        check("t6_data2", tx_data, 16'hAF);
        tick;
        send_sent;
        wait_done("t6_done");
        check("t6_error_end", error, 0);
        check("t6_rd_count", rd_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
